// File: rtl/npc_pkg.sv
// npc core shared definitions: fetch FSM states and default fetch geometry.
package npc_pkg;

    localparam int          DEF_XLEN     = 64;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
    localparam int          INST_W       = 32;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        FULL
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// npc instruction fetch unit: holds the PC, keeps one imem read in flight,
// and hands {pc, inst} to decode; EXU redirects retarget and squash.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst
);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              drop_q, drop_d;

    logic [XLEN-1:0]   tgt;
    logic              req_hs;
    logic              id_hs;

    assign tgt    = redirect_pc & ~XLEN'(3);
    assign req_hs = (state_q == REQ) && imem_req_ready;
    assign id_hs  = (state_q == FULL) && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        unique case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect_valid) pc_d = tgt;
            end
            REQ: begin
                if (redirect_valid) pc_d = tgt;
                if (req_hs) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_d = tgt;
                if (imem_rsp_valid) begin
                    drop_d = 1'b0;
                    // a squashed fetch returns to REQ without touching inst_q
                    if (redirect_valid || drop_q) begin
                        state_d = REQ;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = FULL;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (id_hs) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = pc_q;
        id_valid       = (state_q == FULL);
        id_pc          = pc_q;
        id_inst        = inst_q;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch with a behavioural memory
// and a PC-stream reference model.
`timescale 1ns/1ps
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] t;
        t = a[31:0] * 32'h9E37_79B1;
        return t ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    function automatic logic [63:0] rand_tgt();
        logic [63:0] t;
        if ($urandom_range(3) == 0)
            t = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
        else
            t = RST_PC + 64'($urandom_range(4095));
        return t;
    endfunction

    // Stimulus knobs (percent, per-mille for redirects)
    int          p_ready = 100;
    int          p_idr   = 100;
    int          p_redir = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          f_redir = 1'b0;
    logic [63:0] f_tgt   = '0;

    // Behavioural memory plus redirect/ready driver
    bit          busy = 1'b0;
    int          cnt  = 0;
    logic [63:0] out_addr;
    logic [63:0] acc_q[$];

    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        if (!rst_n) begin
            busy           = 1'b0;
            imem_req_ready = 1'b0;
            id_ready       = 1'b0;
        end else begin
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(out_addr);
                    busy           = 1'b0;
                end
            end
            imem_req_ready = ($urandom_range(99) < p_ready);
            id_ready       = ($urandom_range(99) < p_idr);
            if (f_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = f_tgt;
                f_redir        = 1'b0;
            end else if ($urandom_range(999) < p_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = rand_tgt();
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("single_outstanding", {63'b0, busy}, 64'd0);
                chk("req_align", {62'b0, imem_req_addr[1:0]}, 64'd0);
                busy     = 1'b1;
                out_addr = imem_req_addr;
                cnt      = $urandom_range(lat_max, lat_min);
                acc_q.push_back(imem_req_addr);
            end
        end
    end

    // Reference model: the next PC decode must see
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;

    always @(negedge clk) begin
        bit hs;
        #2;
        if (!rst_n) begin
            model_pc = RST_PC;
            exp_q.delete();
            exp_q.push_back(model_pc);
        end else begin
            hs = id_valid && id_ready;
            if (hs) model_pc = model_pc + 64'd4;
            if (redirect_valid) model_pc = redirect_pc & ~64'h3;
            if (hs || redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(model_pc);
            end
        end
    end

    // Monitor: pops on every decode handshake, checks hold rules
    logic [63:0] dpc_q[$];
    int          dcyc[$];
    bit          h_req, h_id, h_redir;
    logic [63:0] h_addr, h_pc;
    logic [31:0] h_inst;

    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (!rst_n) begin
            h_req = 1'b0;
            h_id  = 1'b0;
        end else begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("id_unexpected", id_pc, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_inst", {32'b0, id_inst}, {32'b0, mem_word(e)});
                end
                dpc_q.push_back(id_pc);
                dcyc.push_back(cyc);
            end
            if (h_req && !h_redir) begin
                chk("req_hold_valid", {63'b0, imem_req_valid}, 64'd1);
                chk("req_hold_addr", imem_req_addr, h_addr);
            end
            if (h_id && !h_redir) begin
                chk("id_hold_valid", {63'b0, id_valid}, 64'd1);
                chk("id_hold_pc", id_pc, h_pc);
                chk("id_hold_inst", {32'b0, id_inst}, {32'b0, h_inst});
            end
            chk("req_while_full", {63'b0, imem_req_valid & id_valid}, 64'd0);
            h_req   = imem_req_valid && !imem_req_ready;
            h_id    = id_valid && !id_ready;
            h_redir = redirect_valid;
            h_addr  = imem_req_addr;
            h_pc    = id_pc;
            h_inst  = id_inst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_q.size() < n && k < 200) begin tick(); k++; end
        if (acc_q.size() < n) chk("acc_timeout", 64'(acc_q.size()), 64'(n));
    endtask

    task automatic wait_del(input int n);
        int k = 0;
        while (dpc_q.size() < n && k < 200) begin tick(); k++; end
        if (dpc_q.size() < n) chk("del_timeout", 64'(dpc_q.size()), 64'(n));
    endtask

    task automatic wait_in_wait();
        int k = 0;
        while (!(busy && !imem_req_valid && !id_valid) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("wait_state_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_sig(input bit want_id);
        int k = 0;
        while (!(want_id ? id_valid : imem_req_valid) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("signal_timeout", {63'b0, want_id}, 64'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {63'b0, imem_req_valid}, 64'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
        chk({tag, "_id_valid"}, {63'b0, id_valid}, 64'd0);
        chk({tag, "_id_pc"}, id_pc, RST_PC);
        chk({tag, "_id_inst"}, {32'b0, id_inst}, 64'd0);
    endtask

    initial begin
        int n0;
        int d0;
        logic [63:0] held;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");

        // Zero-wait memory: 3 cycles per instruction
        #1 rst_n = 1'b1;
        repeat (12) tick();
        if (acc_q.size() >= 3) begin
            chk("bc_addr0", acc_q[0], RST_PC);
            chk("bc_addr1", acc_q[1], RST_PC + 64'd4);
            chk("bc_addr2", acc_q[2], RST_PC + 64'd8);
        end else chk("bc_acc_count", 64'(acc_q.size()), 64'd3);
        if (dcyc.size() >= 3) begin
            chk("bc_gap01", 64'(dcyc[1] - dcyc[0]), 64'd3);
            chk("bc_gap12", 64'(dcyc[2] - dcyc[1]), 64'd3);
        end else chk("bc_del_count", 64'(dcyc.size()), 64'd3);

        // Memory stalls the request
        p_ready = 0;
        wait_sig(1'b0);
        n0 = acc_q.size();
        repeat (5) tick();
        chk("stall_no_acc", 64'(acc_q.size()), 64'(n0));
        chk("stall_valid", {63'b0, imem_req_valid}, 64'd1);
        if (exp_q.size() > 0) chk("stall_addr", imem_req_addr, exp_q[0]);
        p_ready = 100;
        repeat (3) tick();
        chk("stall_one_acc", 64'(acc_q.size()), 64'(n0 + 1));

        // Decode back-pressure in FULL
        p_idr = 0;
        wait_sig(1'b1);
        held = id_pc;
        repeat (4) tick();
        chk("bp_valid", {63'b0, id_valid}, 64'd1);
        chk("bp_pc", id_pc, held);
        chk("bp_inst", {32'b0, id_inst}, {32'b0, mem_word(held)});
        chk("bp_no_req", {63'b0, imem_req_valid}, 64'd0);
        p_idr = 100;

        // Redirect while waiting, no response that cycle
        lat_min = 3; lat_max = 3;
        wait_in_wait();
        n0 = acc_q.size(); d0 = dpc_q.size();
        f_tgt = 64'h8000_1002; f_redir = 1'b1;
        wait_acc(n0 + 1);
        if (acc_q.size() > n0) chk("rw_req", acc_q[n0], 64'h8000_1000);
        wait_del(d0 + 1);
        if (dpc_q.size() > d0) chk("rw_del", dpc_q[d0], 64'h8000_1000);

        // Redirect coincident with the response
        lat_min = 1; lat_max = 1;
        wait_in_wait();
        n0 = acc_q.size(); d0 = dpc_q.size();
        f_tgt = 64'h8000_2000; f_redir = 1'b1;
        wait_acc(n0 + 1);
        if (acc_q.size() > n0) chk("rr_req", acc_q[n0], 64'h8000_2000);
        wait_del(d0 + 1);
        if (dpc_q.size() > d0) chk("rr_del", dpc_q[d0], 64'h8000_2000);

        // Redirect coincident with the decode handshake
        wait_sig(1'b1);
        held = id_pc;
        n0 = acc_q.size(); d0 = dpc_q.size();
        f_tgt = 64'h8000_3000; f_redir = 1'b1;
        wait_acc(n0 + 1);
        if (acc_q.size() > n0) chk("rh_req", acc_q[n0], 64'h8000_3000);
        wait_del(d0 + 2);
        if (dpc_q.size() > d0 + 1) begin
            chk("rh_del0", dpc_q[d0], held);
            chk("rh_del1", dpc_q[d0 + 1], 64'h8000_3000);
        end

        // PC wraps past the top of the address space
        wait_sig(1'b0);
        d0 = dpc_q.size();
        f_tgt = 64'hFFFF_FFFF_FFFF_FFFE; f_redir = 1'b1;
        wait_del(d0 + 2);
        if (dpc_q.size() > d0 + 1) begin
            chk("wrap_del0", dpc_q[d0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_del1", dpc_q[d0 + 1], 64'd0);
        end

        // Randomized traffic
        d0 = dpc_q.size();
        p_ready = 60; p_idr = 70; p_redir = 30;
        lat_min = 1; lat_max = 4;
        repeat (3000) tick();
        p_redir = 0;
        chk("rand_progress", {63'b0, dpc_q.size() > d0 + 100}, 64'd1);

        // Asynchronous reset while waiting on memory
        p_ready = 100; p_idr = 100; lat_min = 3; lat_max = 3;
        wait_in_wait();
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        tick();
        #1 rst_n = 1'b1;
        n0 = acc_q.size(); d0 = dpc_q.size();
        wait_acc(n0 + 1);
        if (acc_q.size() > n0) chk("rst_req", acc_q[n0], RST_PC);
        wait_del(d0 + 1);
        if (dpc_q.size() > d0) chk("rst_del", dpc_q[d0], RST_PC);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
